mips_pipe_hzd: RTL and testbench



---
 rtl/mips_pipe_hzd.sv | 200 ++++++++++++++++++++
 tb/tb_mips_pipe_hzd.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mips_pipe_hzd.sv
// mips_pipe_hzd: single-clock 5-stage MIPS32-subset core with hazard handling.
// `MIPS_FWD_EN enables EX forwarding with a 1-cycle load-use stall; otherwise ID interlocks.
module mips_pipe_hzd #(
   parameter int          IMEM_DEPTH = 1024,
   parameter int          DMEM_DEPTH = 1024,
   parameter logic [31:0] RESET_PC   = 32'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        halted,
   output logic [31:0] pc,
   output logic [31:0] retired,
   output logic        stall,
   input  logic [4:0]  dbg_raddr,
   output logic [31:0] dbg_rdata
);
   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);
`ifdef MIPS_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_AND  = 6'b000010,
                          OP_OR   = 6'b000011, OP_SLT  = 6'b000100, OP_MUL  = 6'b000101,
                          OP_LW   = 6'b001000, OP_SW   = 6'b001001, OP_ADDI = 6'b001010,
                          OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101,
                          OP_BEQZ = 6'b001110, OP_HLT  = 6'b111111;

   typedef struct packed {
      logic        v;
      logic [31:0] ir;
      logic [31:0] npc;
   } ifid_t;

   typedef struct packed {
      logic        v;
      logic [5:0]  op;
      logic [4:0]  rs, rt, dst;
      logic [31:0] a, b, imm, npc;
   } idex_t;

   typedef struct packed {
      logic        v, lw, sw, hlt;
      logic [4:0]  dst;
      logic [31:0] res, sd;
   } exmem_t;

   typedef struct packed {
      logic        v, hlt;
      logic [4:0]  dst;
      logic [31:0] res;
   } memwb_t;

   logic [31:0] IMEM [IMEM_DEPTH];
   logic [31:0] DMEM [DMEM_DEPTH];
   logic [31:0] Reg  [32];

   ifid_t  ifid;
   idex_t  idex, idex_n;
   exmem_t exm, exm_n;
   memwb_t mwb, mwb_n;

   // ID decode
   logic [5:0]  op_d;
   logic [4:0]  rs_d, rt_d, rd_d, dst_d;
   logic        is_r, is_ialu, rd_rs, rd_rt, wb_we;
   logic [31:0] rf_a, rf_b;

   assign op_d    = ifid.ir[31:26];
   assign rs_d    = ifid.ir[25:21];
   assign rt_d    = ifid.ir[20:16];
   assign rd_d    = ifid.ir[15:11];
   assign is_r    = op_d inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
   assign is_ialu = op_d inside {OP_ADDI, OP_SUBI, OP_SLTI};
   assign rd_rs   = is_r | is_ialu | (op_d inside {OP_LW, OP_SW, OP_BEQZ, OP_BNEQZ});
   assign rd_rt   = is_r | (op_d == OP_SW);
   assign dst_d   = is_r ? rd_d : ((is_ialu | (op_d == OP_LW)) ? rt_d : 5'd0);

   // WB write is visible to the ID read in the same cycle
   assign wb_we = mwb.v & ~halted & (mwb.dst != 5'd0);
   assign rf_a  = (rs_d == 5'd0) ? 32'd0 : ((wb_we && mwb.dst == rs_d) ? mwb.res : Reg[rs_d]);
   assign rf_b  = (rt_d == 5'd0) ? 32'd0 : ((wb_we && mwb.dst == rt_d) ? mwb.res : Reg[rt_d]);
   assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : Reg[dbg_raddr];

   always_comb begin
      idex_n     = '0;
      idex_n.v   = ifid.v;
      idex_n.op  = op_d;
      idex_n.rs  = rs_d;
      idex_n.rt  = rt_d;
      idex_n.dst = dst_d;
      idex_n.a   = rf_a;
      idex_n.b   = rf_b;
      idex_n.imm = {{16{ifid.ir[15]}}, ifid.ir[15:0]};
      idex_n.npc = ifid.npc;
   end

   // Hazard detection
   logic hit_ex, hit_mem, hz, take, freeze, hlt_hold;
   assign hit_ex  = idex.v & (idex.dst != 5'd0) &
                    ((rd_rs & (rs_d == idex.dst)) | (rd_rt & (rt_d == idex.dst)));
   assign hit_mem = exm.v & (exm.dst != 5'd0) &
                    ((rd_rs & (rs_d == exm.dst)) | (rd_rt & (rt_d == exm.dst)));
   assign hz      = ifid.v & (FWD ? (hit_ex & (idex.op == OP_LW)) : (hit_ex | hit_mem));
   assign freeze  = halted | (mwb.v & mwb.hlt);
   assign hlt_hold = (ifid.v & (op_d == OP_HLT)) | (idex.v & (idex.op == OP_HLT)) |
                     (exm.v & exm.hlt) | (mwb.v & mwb.hlt);
   assign stall   = hz & ~take & ~freeze;

   // EX: forwarded operands, ALU, branch resolve
   logic [31:0] a, b, alu;
   always_comb begin
      a = idex.a;
      b = idex.b;
      if (FWD && exm.v && exm.dst != 5'd0 && exm.dst == idex.rs)      a = exm.res;
      else if (FWD && mwb.v && mwb.dst != 5'd0 && mwb.dst == idex.rs) a = mwb.res;
      if (FWD && exm.v && exm.dst != 5'd0 && exm.dst == idex.rt)      b = exm.res;
      else if (FWD && mwb.v && mwb.dst != 5'd0 && mwb.dst == idex.rt) b = mwb.res;
   end

   always_comb begin
      alu = '0;
      case (idex.op)
         OP_ADD:               alu = a + b;
         OP_SUB:               alu = a - b;
         OP_AND:               alu = a & b;
         OP_OR:                alu = a | b;
         OP_SLT:               alu = {31'd0, $signed(a) < $signed(b)};
         OP_MUL:               alu = a * b;
         OP_LW, OP_SW, OP_ADDI: alu = a + idex.imm;
         OP_SUBI:              alu = a - idex.imm;
         OP_SLTI:              alu = {31'd0, $signed(a) < $signed(idex.imm)};
         default:              alu = '0;
      endcase
   end

   assign take = idex.v & (((idex.op == OP_BEQZ) & (a == 32'd0)) |
                           ((idex.op == OP_BNEQZ) & (a != 32'd0)));

   always_comb begin
      exm_n     = '0;
      exm_n.v   = idex.v;
      exm_n.lw  = idex.op == OP_LW;
      exm_n.sw  = idex.op == OP_SW;
      exm_n.hlt = idex.op == OP_HLT;
      exm_n.dst = idex.dst;
      exm_n.res = alu;
      exm_n.sd  = b;
   end

   always_comb begin
      mwb_n     = '0;
      mwb_n.v   = exm.v;
      mwb_n.hlt = exm.hlt;
      mwb_n.dst = exm.dst;
      mwb_n.res = exm.lw ? DMEM[exm.res[DAW-1:0]] : exm.res;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_PC;
         halted  <= 1'b0;
         retired <= '0;
         ifid    <= '0;
         idex    <= '0;
         exm     <= '0;
         mwb     <= '0;
      end else if (!halted) begin
         retired <= retired + 32'(mwb.v);
         if (mwb.v & mwb.hlt) begin
            halted <= 1'b1;
         end else begin
            mwb <= mwb_n;
            exm <= exm_n;
            if (take) begin
               pc   <= idex.npc + idex.imm;
               ifid <= '0;
               idex <= '0;
            end else if (hz) begin
               idex <= '0;
            end else begin
               idex <= idex_n;
               if (hlt_hold) begin
                  ifid <= '0;
               end else begin
                  pc   <= pc + 32'd1;
                  ifid <= '{v: 1'b1, ir: IMEM[pc[IAW-1:0]], npc: pc + 32'd1};
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!freeze && exm.v && exm.sw) DMEM[exm.res[DAW-1:0]] <= exm.sd;
      if (wb_we)                      Reg[mwb.dst] <= mwb.res;
   end
endmodule

// File: tb/tb_mips_pipe_hzd.sv
// Directed bench for mips_pipe_hzd: hazard programs, halt timing, reset behaviour.
module tb_mips_pipe_hzd;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        halted, stall;
   logic [31:0] pc, retired, dbg_rdata;
   logic [4:0]  dbg_raddr = 5'd0;
   int          checks = 0;
   int          failures = 0;

`ifdef MIPS_FWD_EN
   localparam int FWD_HALT = 9,  FWD_STALLS = 0, LU_HALT = 9,  LU_STALLS = 1;
`else
   localparam int FWD_HALT = 13, FWD_STALLS = 4, LU_HALT = 12, LU_STALLS = 4;
`endif
   localparam logic [31:0] HLT = 32'hFC000000;

   mips_pipe_hzd dut (
      .clk(clk), .rst_n(rst_n), .halted(halted), .pc(pc), .retired(retired),
      .stall(stall), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rty(input logic [5:0] op, input int rd, input int rs, input int rt);
      return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   function automatic logic [31:0] ity(input logic [5:0] op, input int rt, input int rs, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   task automatic hold_reset();
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 32; i++) dut.IMEM[i] = 32'd0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_halt(input int max, output int edge_at, output int stalls);
      edge_at = -1;
      stalls  = 0;
      for (int n = 1; n <= max; n++) begin
         @(posedge clk);
         #1;
         if (stall) stalls++;
         if (halted) begin
            edge_at = n;
            break;
         end
      end
   endtask

   task automatic rd_reg(input int r, output logic [31:0] v);
      dbg_raddr = 5'(r);
      #1;
      v = dbg_rdata;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      checks++; if (pc !== 32'd0)      begin failures++; $display("FAIL reset_pc: got %0d expected 0", pc); end
      checks++; if (halted !== 1'b0)   begin failures++; $display("FAIL reset_halted: got %b expected 0", halted); end
      checks++; if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired: got %0d expected 0", retired); end
      checks++; if (stall !== 1'b0)    begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
   endtask

   task automatic test_fwd();
      int e, s;
      logic [31:0] v;
      hold_reset();
      dut.Reg[4] = 32'hDEAD; dut.Reg[5] = 32'hDEAD;
      dut.IMEM[0] = ity(6'b001010, 1, 0, 10);
      dut.IMEM[1] = ity(6'b001010, 2, 0, 20);
      dut.IMEM[2] = rty(6'b000000, 4, 1, 2);
      dut.IMEM[3] = rty(6'b000000, 5, 4, 1);
      dut.IMEM[4] = HLT;
      release_reset();
      run_halt(100, e, s);
      checks++; if (e != FWD_HALT)   begin failures++; $display("FAIL fwd_halt_edge: got %0d expected %0d", e, FWD_HALT); end
      checks++; if (s != FWD_STALLS) begin failures++; $display("FAIL fwd_stalls: got %0d expected %0d", s, FWD_STALLS); end
      checks++; if (retired !== 32'd5) begin failures++; $display("FAIL fwd_retired: got %0d expected 5", retired); end
      checks++; if (pc !== 32'd5)    begin failures++; $display("FAIL fwd_pc: got %0d expected 5", pc); end
      rd_reg(4, v);
      checks++; if (v !== 32'd30) begin failures++; $display("FAIL fwd_r4: got %0d expected 30", v); end
      rd_reg(5, v);
      checks++; if (v !== 32'd40) begin failures++; $display("FAIL fwd_r5: got %0d expected 40", v); end
   endtask

   task automatic test_load_use();
      int e, s;
      logic [31:0] v;
      hold_reset();
      dut.DMEM[100] = 32'h55;
      dut.Reg[3] = 32'd0;
      dut.IMEM[0] = ity(6'b001010, 1, 0, 100);
      dut.IMEM[1] = ity(6'b001000, 2, 1, 0);
      dut.IMEM[2] = rty(6'b000000, 3, 2, 2);
      dut.IMEM[3] = HLT;
      release_reset();
      run_halt(100, e, s);
      checks++; if (e != LU_HALT)   begin failures++; $display("FAIL lu_halt_edge: got %0d expected %0d", e, LU_HALT); end
      checks++; if (s != LU_STALLS) begin failures++; $display("FAIL lu_stalls: got %0d expected %0d", s, LU_STALLS); end
      checks++; if (retired !== 32'd4) begin failures++; $display("FAIL lu_retired: got %0d expected 4", retired); end
      rd_reg(3, v);
      checks++; if (v !== 32'hAA) begin failures++; $display("FAIL lu_r3: got %0h expected aa", v); end
   endtask

   task automatic load_fact();
      dut.IMEM[0] = ity(6'b001010, 10, 0, 5);
      dut.IMEM[1] = ity(6'b001010, 2, 0, 1);
      dut.IMEM[2] = rty(6'b000101, 2, 2, 10);
      dut.IMEM[3] = ity(6'b001011, 10, 10, 1);
      dut.IMEM[4] = ity(6'b001101, 0, 10, -3);
      dut.IMEM[5] = HLT;
   endtask

   task automatic test_branch_loop();
      int e, s;
      logic [31:0] v;
      hold_reset();
      load_fact();
      release_reset();
      run_halt(300, e, s);
      checks++; if (e < 0) begin failures++; $display("FAIL br_halted: got timeout expected halt"); end
      checks++; if (retired !== 32'd18) begin failures++; $display("FAIL br_retired: got %0d expected 18", retired); end
      checks++; if (pc !== 32'd6) begin failures++; $display("FAIL br_pc: got %0d expected 6", pc); end
      rd_reg(2, v);
      checks++; if (v !== 32'd120) begin failures++; $display("FAIL br_r2: got %0d expected 120", v); end
      rd_reg(10, v);
      checks++; if (v !== 32'd0) begin failures++; $display("FAIL br_r10: got %0d expected 0", v); end
   endtask

   task automatic test_store_load();
      int e, s;
      logic [31:0] v;
      hold_reset();
      dut.Reg[0] = 32'hDEADBEEF;
      dut.Reg[3] = 32'd0; dut.Reg[4] = 32'h1234;
      dut.DMEM[20] = 32'd0;
      dut.IMEM[0] = ity(6'b001010, 1, 0, 7);
      dut.IMEM[1] = ity(6'b001001, 1, 0, 20);
      dut.IMEM[2] = ity(6'b001000, 3, 0, 20);
      dut.IMEM[3] = ity(6'b001010, 0, 0, 5);
      dut.IMEM[4] = rty(6'b000000, 4, 0, 0);
      dut.IMEM[5] = HLT;
      release_reset();
      run_halt(100, e, s);
      checks++; if (retired !== 32'd6) begin failures++; $display("FAIL sl_retired: got %0d expected 6", retired); end
      checks++; if (dut.DMEM[20] !== 32'd7) begin failures++; $display("FAIL sl_dmem20: got %0d expected 7", dut.DMEM[20]); end
      rd_reg(3, v);
      checks++; if (v !== 32'd7) begin failures++; $display("FAIL sl_r3: got %0d expected 7", v); end
      rd_reg(4, v);
      checks++; if (v !== 32'd0) begin failures++; $display("FAIL sl_r4: got %0d expected 0", v); end
      rd_reg(0, v);
      checks++; if (v !== 32'd0) begin failures++; $display("FAIL sl_dbg_r0: got %0h expected 0", v); end
   endtask

   task automatic test_reset_mid();
      int e, s;
      logic [31:0] v;
      hold_reset();
      load_fact();
      release_reset();
      repeat (14) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (pc !== 32'd0)      begin failures++; $display("FAIL mid_pc: got %0d expected 0", pc); end
      checks++; if (halted !== 1'b0)   begin failures++; $display("FAIL mid_halted: got %b expected 0", halted); end
      checks++; if (retired !== 32'd0) begin failures++; $display("FAIL mid_retired: got %0d expected 0", retired); end
      repeat (2) @(posedge clk);
      release_reset();
      run_halt(300, e, s);
      checks++; if (halted !== 1'b1) begin failures++; $display("FAIL mid_rerun_halted: got %b expected 1", halted); end
      checks++; if (retired !== 32'd18) begin failures++; $display("FAIL mid_rerun_retired: got %0d expected 18", retired); end
      rd_reg(2, v);
      checks++; if (v !== 32'd120) begin failures++; $display("FAIL mid_rerun_r2: got %0d expected 120", v); end
   endtask

   initial begin
      test_reset();
      test_fwd();
      test_load_use();
      test_branch_loop();
      test_store_load();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
